// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory access controller.
package mem_access_ctrl_pkg;

    // Controller states: waiting for an op, op outstanding, op completed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Default number of ACCESS cycles allowed without an acknowledge.
    localparam int unsigned DEFAULT_TIMEOUT = 32'd15;

    // Default width of the timeout counter.
    localparam int unsigned DEFAULT_CNT_W = 32'd4;

endpackage

// File: rtl/mem_access_ctrl_access_timer.sv
// Saturating wait-cycle counter for an outstanding memory access.
// 'expired' is raised while the count sits at TIMEOUT-1, i.e. during the
// last ACCESS cycle that may still receive an acknowledge.
module access_timer #(
    parameter int unsigned CNT_W   = 32'd4,
    parameter int unsigned TIMEOUT = 32'd15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access sequencer: issues a registered req/ack
// transaction per load/store, freezes the pipeline while it is outstanding,
// and returns load data or a timeout pulse to write-back.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32'd32,
    parameter int unsigned DATA_W  = 32'd32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [ADDR_W-1:0] Addr_in,
    input  logic [DATA_W-1:0] WriteData_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wb_bubble,
    output logic [DATA_W-1:0] ReadData_out,
    output logic              bus_error
);

    state_e            state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              bus_error_q, bus_error_d;

    logic access;
    logic busy;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    access_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign access = MemRead_in | MemWrite_in;

    // Next-state and next-register logic; busy marks cycles that freeze the pipe.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_error_d = 1'b0;
        busy        = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    busy        = 1'b1;
                    state_d     = ST_ACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite_in;   // store wins when both are set
                    mem_addr_d  = Addr_in;
                    mem_wdata_d = WriteData_in;
                    tmr_clr     = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                busy = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (tmr_expired) begin
                    mem_req_d   = 1'b0;
                    rdata_d     = {DATA_W{1'b0}};
                    bus_error_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    tmr_en      = 1'b1;
                end
            end
            ST_DONE: begin
                // Inputs still belong to the instruction just completed.
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Pipeline control is suppressed while reset is held.
    always_comb begin
        stall     = busy & ~reset;
        wb_bubble = busy & ~reset;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign ReadData_out = rdata_q;
    assign bus_error    = bus_error_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage of the 5-stage pipeline against a variable-latency memory with a req/ack handshake. While an access is outstanding it freezes the upstream pipeline and forces a bubble into the MEM/WB stage register. It supplies the load data and a timeout error to WB and hazard logic. Sits between the EX/MEM register outputs, the data memory port and the MEM/WB register inputs.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, max ACCESS cycles without mem_ack before abort (1..2^CNT_W-1)
CNT_W, 4, timeout counter width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
MemRead_in  in  1  load in MEM stage (from EX/MEM)
MemWrite_in  in  1  store in MEM stage (from EX/MEM)
Addr_in  in  ADDR_W  ALU result / effective address
WriteData_in  in  DATA_W  store data
mem_req  out  1  registered request to memory
mem_we  out  1  registered write enable, valid with mem_req
mem_addr  out  ADDR_W  registered address, valid with mem_req
mem_wdata  out  DATA_W  registered store data
mem_ack  in  1  memory completion, one cycle, sampled only in ACCESS
mem_rdata  in  DATA_W  load data, valid with mem_ack
stall  out  1  combinational: hold PC, IF/ID, ID/EX, EX/MEM
wb_bubble  out  1  combinational: force MEM/WB RegWrite/MemtoReg to 0
ReadData_out  out  DATA_W  registered load data to MEM/WB Mem_ReadData_in
bus_error  out  1  registered one-cycle timeout pulse

Behaviour:
- States: IDLE, ACCESS, DONE. Reset -> IDLE, counter 0. mem_req, mem_we, mem_addr, mem_wdata, ReadData_out and bus_error are 0 at reset. stall and wb_bubble are forced 0 while reset is high.
- access = MemRead_in | MemWrite_in. If both are set, the store wins (mem_we=1).
- IDLE:
  - access=0: stall=0, stay in IDLE.
  - access=1: stall=wb_bubble=1 this cycle. At the edge, latch Addr_in and WriteData_in, set mem_req=1, set mem_we=MemWrite_in, clear the counter, go to ACCESS.
- ACCESS: stall=wb_bubble=1, mem_req held high, address and data stable.
  - mem_ack=1: at the edge, ReadData_out<=mem_rdata (loads only; a store leaves ReadData_out unchanged), mem_req<=0, go to DONE.
  - mem_ack=0 and counter==TIMEOUT-1: at the edge, mem_req<=0, ReadData_out<=0, bus_error<=1 for one cycle, go to DONE.
  - Otherwise the counter increments.
- DONE: stall=wb_bubble=0, so the instruction advances into MEM/WB at this edge with ReadData_out valid. MemRead_in/MemWrite_in are ignored here because they belong to the same instruction. Always go to IDLE.
- Latency: an ack in the first ACCESS cycle gives 2 stall cycles per memory op. An ack after k extra cycles gives 2+k stall cycles. A timeout gives TIMEOUT+1 stall cycles.
- Back-to-back memory ops: DONE -> IDLE, and the next op is detected in IDLE. This adds no extra bubble beyond the 2 stall cycles.
- mem_ack outside ACCESS (late ack after timeout, spurious ack) is ignored and does not touch ReadData_out.
- Reset mid-ACCESS: mem_req drops at that edge and no bus_error is raised. The pending access is abandoned.
- Counter saturates and never wraps. It is cleared on entry to ACCESS.

Decomposition:
- Shared package: state encoding (IDLE, ACCESS, DONE) and the default TIMEOUT constant.
- One natural sub-module: access_timer (clear, enable, CNT_W counter, expired flag at TIMEOUT-1). The FSM and registers stay in mem_access_ctrl.

Test Plan:
- Load, addr 0x100, mem_ack in first ACCESS cycle with rdata 0xCAFEF00D -> stall high for 2 cycles; ReadData_out=0xCAFEF00D in DONE; mem_req high for exactly 1 cycle; mem_we=0.
- Store, addr 0x104, data 0x12345678, ack after 3 wait cycles -> mem_we=1, mem_addr/mem_wdata stable for all 4 ACCESS cycles; stall high 5 cycles; ReadData_out unchanged.
- No ack, TIMEOUT=15 -> bus_error pulses once; ReadData_out=0; stall high 16 cycles; a late ack 2 cycles after DONE is ignored.
- Back-to-back loads (0x200, then 0x204, each acked immediately) -> two distinct requests, stall pattern 1,1,0,1,1,0; each ReadData_out matches its own rdata.
- MemRead and MemWrite both set -> mem_we=1. reset asserted in the 2nd ACCESS cycle -> mem_req=0 and state IDLE next cycle, stall=0 during reset, no bus_error.
